ex_muldiv_unit: RTL and testbench

- EX-stage consumer of the ID/EX pipeline register outputs; executes RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively.
- Receives funct3 and operands launched by the ID/EX register and returns a result at a fixed latency.
- Raises stall_req to freeze the PC, IF/ID and ID/EX while the operation runs, so the ID/EX outputs stay stable.

---
 rtl/ex_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Fixed 34-cycle latency from accepted start to the one-cycle done pulse.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall_req
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [5:0]        counter;
    logic [2:0]        fn_r;
    logic [XLEN-1:0]   a_reg;
    logic [XLEN-1:0]   b_reg;
    logic [XLEN-1:0]   a_raw;
    logic [2*XLEN-1:0] acc;
    logic              res_neg;
    logic              rem_neg;
    logic              div_zero;
    logic              div_ovf;

    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic sgn_a;
    logic sgn_b;
    logic accept;

    // MULH, MULHSU, DIV, REM treat op_a as signed; MULHSU leaves op_b unsigned.
    assign sgn_a  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sgn_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign accept = start && !flush && ((state == S_IDLE) || (state == S_DONE));

    assign busy      = (state == S_CALC) || (state == S_FIX);
    assign done      = (state == S_DONE);
    assign stall_req = busy || accept;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   rem_next;

    // Multiply adds into the upper half and shifts right; divide shifts the dividend in from a_reg.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (b_reg[0] ? {1'b0, a_reg} : {(XLEN+1){1'b0}});
    assign div_trial = {acc[2*XLEN-1:XLEN], a_reg[XLEN-1]};
    assign div_ge    = div_trial >= {1'b0, b_reg};
    assign div_diff  = div_trial[XLEN-1:0] - b_reg;
    assign rem_next  = div_ge ? div_diff : div_trial[XLEN-1:0];

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   sel_fix;

    always_comb begin
        prod_fix = neg_wide_if(acc, res_neg);
        quo_fix  = neg_if(acc[XLEN-1:0], res_neg);
        rem_fix  = neg_if(acc[2*XLEN-1:XLEN], rem_neg);
        if (div_zero) begin
            quo_fix = '1;
            rem_fix = a_raw;
        end else if (div_ovf) begin
            quo_fix = INT_MIN;
            rem_fix = '0;
        end
        case (fn_r)
            3'b000:                 sel_fix = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel_fix = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel_fix = quo_fix;
            default:                sel_fix = rem_fix;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            counter  <= '0;
            fn_r     <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            a_raw    <= '0;
            acc      <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            state   <= S_IDLE;
            counter <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        fn_r     <= funct3;
                        a_reg    <= abs_if(op_a, sgn_a);
                        b_reg    <= abs_if(op_b, sgn_b);
                        a_raw    <= op_a;
                        acc      <= '0;
                        res_neg  <= (sgn_a && op_a[XLEN-1]) ^ (sgn_b && op_b[XLEN-1]);
                        rem_neg  <= sgn_a && op_a[XLEN-1];
                        div_zero <= funct3[2] && (op_b == '0);
                        div_ovf  <= funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
                        counter  <= '0;
                        state    <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (fn_r[2]) begin
                        acc   <= {rem_next, acc[XLEN-2:0], div_ge};
                        a_reg <= a_reg << 1;
                    end else begin
                        acc   <= {mul_sum, acc[XLEN-1:1]};
                        b_reg <= b_reg >> 1;
                    end
                    counter <= counter + 6'd1;
                    if (counter == 6'd31) state <= S_FIX;
                end
                default: begin
                    result <= sel_fix;
                    state  <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed, special-case, random, flush, reset and back-to-back scenarios.
module tb_ex_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall_req;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_res = '0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
        .done(done), .result(result), .stall_req(stall_req)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Architectural RV32M semantics computed with wide integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint ub;
        longint p;
        longint unsigned pu;
        int q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done; lat is the cycle count from start, -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge CLK);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        tests++;
        if ({busy, done, stall_req, result} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b stall=%b result=%h, required all 0",
                     busy, done, stall_req, result);
        end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mul_latency();
        int lat;
        @(negedge CLK);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD;
        #1;
        tests++;
        if (stall_req !== 1'b1) begin
            fails++;
            $display("FAIL stall_cycle0: stall_req=%b, required 1", stall_req);
        end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
            if (k < 34) begin
                tests++;
                if (stall_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_cycle%0d: stall=%b busy=%b done=%b, required 1 1 0", k, stall_req, busy, done);
                end
            end
            if (done) begin lat = k; break; end
        end
        tests++;
        if (lat != 34 || stall_req !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFFEB) begin
            fails++;
            $display("FAIL mul_latency: lat=%0d stall=%b busy=%b result=%h, required 34 0 0 ffffffeb",
                     lat, stall_req, busy, result);
        end
        last_res = result;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        logic [31:0] res;
        int lat;
        v[0]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        v[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        v[2]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        v[3]  = '{3'b101, 32'd100,      32'd7,        32'd14};
        v[4]  = '{3'b111, 32'd100,      32'd7,        32'd2};
        v[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        v[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        v[7]  = '{3'b100, 32'h12345678, 32'd0,        32'hFFFFFFFF};
        v[8]  = '{3'b110, 32'h12345678, 32'd0,        32'h12345678};
        v[9]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        v[10] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        v[11] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
        for (int i = 0; i < 12; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, res, lat);
            tests++;
            if (res !== v[i].exp || lat != 34) begin
                fails++;
                $display("FAIL directed%0d f=%0d a=%h b=%h: result=%h lat=%0d, required %h lat 34",
                         i, v[i].f, v[i].a, v[i].b, res, lat, v[i].exp);
            end
            last_res = res;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp = model(f, a, b);
            run_op(f, a, b, res, lat);
            tests++;
            if (res !== exp || lat != 34) begin
                fails++;
                $display("FAIL random%0d f=%0d a=%h b=%h: result=%h lat=%0d, required %h lat 34",
                         i, f, a, b, res, lat, exp);
            end
            last_res = res;
        end
    endtask

    task automatic test_flush();
        int saw_done;
        @(negedge CLK);
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
        end
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        tests++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop: busy=%b stall=%b, required 0 0", busy, stall_req);
        end
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (done) saw_done++;
        end
        tests++;
        if (saw_done != 0 || result !== last_res) begin
            fails++;
            $display("FAIL flush_result: done pulses=%0d result=%h, required 0 pulses result %h",
                     saw_done, result, last_res);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        @(negedge CLK);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd3;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
            if (k >= 5 && k < 9) begin
                start = 1'b1; funct3 = 3'b101; op_a = $urandom; op_b = $urandom;
            end
            if (k == 9) start = 1'b0;
            if (done) begin lat = k; break; end
        end
        tests++;
        if (lat != 34 || result !== 32'd21) begin
            fails++;
            $display("FAIL ignored_start: lat=%0d result=%h, required 34 00000015", lat, result);
        end
        last_res = result;
    endtask

    task automatic test_async_reset();
        int saw_done;
        @(negedge CLK);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
        end
        #1 RESET = 1'b0;
        #1;
        tests++;
        if ({busy, done, stall_req, result} !== 35'd0) begin
            fails++;
            $display("FAIL async_reset: busy=%b done=%b stall=%b result=%h, required all 0",
                     busy, done, stall_req, result);
        end
        @(negedge CLK);
        RESET = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (done) saw_done++;
        end
        tests++;
        if (saw_done != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: done pulses=%0d busy=%b, required 0 0", saw_done, busy);
        end
        last_res = '0;
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        logic [31:0] r1;
        logic gap_busy;
        @(negedge CLK);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd9;
        lat1 = -1; lat2 = -1; r1 = '0; gap_busy = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) start = 1'b0;
            if (done) begin lat1 = k; r1 = result; break; end
        end
        start = 1'b1; funct3 = 3'b110; op_a = 32'hFFFFFC18; op_b = 32'd7;
        #1;
        tests++;
        if (stall_req !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stall: stall_req=%b in done cycle with start, required 1", stall_req);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) begin start = 1'b0; gap_busy = busy; end
            if (done) begin lat2 = k; break; end
        end
        tests++;
        if (lat1 != 34 || r1 !== 32'd111 || gap_busy !== 1'b1 || lat2 != 34 || result !== 32'hFFFFFFFA) begin
            fails++;
            $display("FAIL back_to_back: lat1=%0d r1=%h busy_after=%b lat2=%0d r2=%h, required 34 0000006f 1 34 fffffffa",
                     lat1, r1, gap_busy, lat2, result);
        end
        last_res = result;
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_directed();
        test_random();
        test_flush();
        test_ignored_start();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
